// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the HH:MM:SS digit sequencer.
// CLOCK_12H_EN selects 12-hour limits (01..12) instead of 24-hour (00..23).
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HR  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;
    localparam logic [1:0] MODE_CLEAR   = 2'd3;

    localparam int SEC_O = 0;
    localparam int SEC_T = 1;
    localparam int MIN_O = 2;
    localparam int MIN_T = 3;
    localparam int HR_O  = 4;
    localparam int HR_T  = 5;

    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

`ifdef CLOCK_12H_EN
    localparam logic [3:0]  HR_LIM_T     = 4'd1;
    localparam logic [3:0]  HR_LIM_O     = 4'd2;
    localparam logic [3:0]  HR_WRAP_T    = 4'd0;
    localparam logic [3:0]  HR_WRAP_O    = 4'd1;
    localparam logic [23:0] CLEAR_DIGITS = 24'h120000;
`else
    localparam logic [3:0]  HR_LIM_T     = 4'd2;
    localparam logic [3:0]  HR_LIM_O     = 4'd3;
    localparam logic [3:0]  HR_WRAP_T    = 4'd0;
    localparam logic [3:0]  HR_WRAP_O    = 4'd0;
    localparam logic [23:0] CLEAR_DIGITS = 24'h000000;
`endif

    // True at or beyond the field's top value, so garbage digits also wrap.
    function automatic logic at_limit(input logic [3:0] t, input logic [3:0] o,
                                      input logic [3:0] lim_t, input logic [3:0] lim_o);
        return (t > lim_t) || ((t == lim_t) && (o >= lim_o));
    endfunction

    // Next two-digit value of a field for the set-mode increment.
    function automatic logic [7:0] field_next(input logic [3:0] t, input logic [3:0] o,
                                              input logic [3:0] lim_t, input logic [3:0] lim_o,
                                              input logic [3:0] wrap_t, input logic [3:0] wrap_o);
        if (at_limit(t, o, lim_t, lim_o))
            return {wrap_t, wrap_o};
        else if (o >= ONES_MAX)
            return {t + 4'd1, 4'd0};
        else
            return {t, o + 4'd1};
    endfunction

endpackage

// File: rtl/clock_rollover.sv
// Combinational per-second carry logic: which digits count or get rewritten on a tick.
// CLOCK_12H_EN adds the AM/PM flip output and 12->01 hour wrap.
module clock_rollover
    import clock_ctrl_pkg::*;
(
    input  logic [23:0] digits,
    output logic [5:0]  ena,
    output logic [5:0]  wr,
    output logic [23:0] wdata
`ifdef CLOCK_12H_EN
    ,
    output logic        pm_flip
`endif
);

    logic [3:0] sec_o, sec_t, min_o, min_t, hr_o, hr_t;
    logic       sec_wrap, min_wrap, hr_wrap;

    assign sec_o = digits[SEC_O*4 +: 4];
    assign sec_t = digits[SEC_T*4 +: 4];
    assign min_o = digits[MIN_O*4 +: 4];
    assign min_t = digits[MIN_T*4 +: 4];
    assign hr_o  = digits[HR_O*4 +: 4];
    assign hr_t  = digits[HR_T*4 +: 4];

    // Carry out of a base-6 tens digit uses >= so out-of-range values roll too.
    assign sec_wrap = (sec_o == ONES_MAX) && (sec_t >= TENS_MAX);
    assign min_wrap = (min_o == ONES_MAX) && (min_t >= TENS_MAX);
    assign hr_wrap  = at_limit(hr_t, hr_o, HR_LIM_T, HR_LIM_O);

    always_comb begin
        ena   = '0;
        wr    = '0;
        wdata = '0;
        ena[SEC_O] = 1'b1;
        if (sec_o == ONES_MAX) begin
            ena[SEC_T] = 1'b1;
            wr[SEC_T]  = (sec_t >= TENS_MAX);
        end
        if (sec_wrap) begin
            ena[MIN_O] = 1'b1;
            if (min_o == ONES_MAX) begin
                ena[MIN_T] = 1'b1;
                wr[MIN_T]  = (min_t >= TENS_MAX);
            end
        end
        if (sec_wrap && min_wrap) begin
            ena[HR_O] = 1'b1;
            if (hr_wrap) begin
                ena[HR_T]            = 1'b1;
                wr[HR_T]             = 1'b1;
                wr[HR_O]             = 1'b1;
                wdata[HR_T*4 +: 4]   = HR_WRAP_T;
                wdata[HR_O*4 +: 4]   = HR_WRAP_O;
            end else if (hr_o == ONES_MAX) begin
                ena[HR_T] = 1'b1;
            end
        end
    end

`ifdef CLOCK_12H_EN
    assign pm_flip = sec_wrap && min_wrap && (hr_t == 4'd1) && (hr_o == 4'd1);
`endif

endmodule

// File: rtl/clock_time_controller.sv
// Mode FSM and registered digit enable/write outputs for the HH:MM:SS counter bank.
// CLOCK_12H_EN: 12-hour mode with o_pm output; default build is 24-hour.
module clock_time_controller
    import clock_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_tick,
    input  logic        i_mode,
    input  logic        i_inc,
    input  logic [23:0] i_digits,
    output logic [5:0]  o_ena,
    output logic [5:0]  o_wr,
    output logic [23:0] o_wdata,
    output logic [1:0]  o_mode
`ifdef CLOCK_12H_EN
    ,
    output logic        o_pm
`endif
);

    state_t      state, next_state;
    logic        busy, inc_take;
    logic [5:0]  ena_d, wr_d, roll_ena, roll_wr;
    logic [23:0] wdata_d, roll_wdata;
    logic [1:0]  mode_d;
    logic [7:0]  hr_next, min_next;
`ifdef CLOCK_12H_EN
    logic        pm_flip, pm_d;
`endif

    clock_rollover u_rollover (
        .digits (i_digits),
        .ena    (roll_ena),
        .wr     (roll_wr),
        .wdata  (roll_wdata)
`ifdef CLOCK_12H_EN
        ,
        .pm_flip(pm_flip)
`endif
    );

    assign hr_next  = field_next(i_digits[HR_T*4 +: 4], i_digits[HR_O*4 +: 4],
                                 HR_LIM_T, HR_LIM_O, HR_WRAP_T, HR_WRAP_O);
    assign min_next = field_next(i_digits[MIN_T*4 +: 4], i_digits[MIN_O*4 +: 4],
                                 TENS_MAX, ONES_MAX, 4'd0, 4'd0);

    always_comb begin
        next_state = state;
        ena_d      = '0;
        wr_d       = '0;
        wdata_d    = '0;
        inc_take   = 1'b0;
`ifdef CLOCK_12H_EN
        pm_d       = o_pm;
`endif
        case (state)
            ST_CLEAR: begin
                ena_d      = 6'h3F;
                wr_d       = 6'h3F;
                wdata_d    = CLEAR_DIGITS;
                next_state = ST_RUN;
`ifdef CLOCK_12H_EN
                pm_d       = 1'b0;
`endif
            end
            ST_RUN: begin
                if (i_tick) begin
                    ena_d   = roll_ena;
                    wr_d    = roll_wr;
                    wdata_d = roll_wdata;
`ifdef CLOCK_12H_EN
                    pm_d    = o_pm ^ pm_flip;
`endif
                end
                if (i_mode)
                    next_state = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (i_mode) begin
                    next_state = ST_SET_MIN;
                end else if (i_inc && !busy) begin
                    inc_take            = 1'b1;
                    ena_d[HR_T:HR_O]    = 2'b11;
                    wr_d[HR_T:HR_O]     = 2'b11;
                    wdata_d[23:16]      = hr_next;
                end
            end
            ST_SET_MIN: begin
                if (i_mode) begin
                    // Leaving set mode restarts the minute from :00.
                    next_state           = ST_RUN;
                    ena_d[SEC_T:SEC_O]   = 2'b11;
                    wr_d[SEC_T:SEC_O]    = 2'b11;
                end else if (i_inc && !busy) begin
                    inc_take             = 1'b1;
                    ena_d[MIN_T:MIN_O]   = 2'b11;
                    wr_d[MIN_T:MIN_O]    = 2'b11;
                    wdata_d[15:8]        = min_next;
                end
            end
            default: next_state = ST_CLEAR;
        endcase
        // The clear pulse still reports CLEAR; otherwise show the mode being entered.
        mode_d = (state == ST_CLEAR) ? MODE_CLEAR : 2'(next_state);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_CLEAR;
            busy    <= 1'b0;
            o_ena   <= '0;
            o_wr    <= '0;
            o_wdata <= '0;
            o_mode  <= MODE_CLEAR;
`ifdef CLOCK_12H_EN
            o_pm    <= 1'b0;
`endif
        end else begin
            state   <= next_state;
            busy    <= inc_take;
            o_ena   <= ena_d;
            o_wr    <= wr_d;
            o_wdata <= wdata_d;
            o_mode  <= mode_d;
`ifdef CLOCK_12H_EN
            o_pm    <= pm_d;
`endif
        end
    end

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller (24-hour build) with a behavioural digit counter bank.
module tb_clock_time_controller;

    logic        clk, reset, tick, mode, inc;
    logic [23:0] digits;
    logic [5:0]  ena, wr;
    logic [23:0] wdata;
    logic [1:0]  omode;
`ifdef CLOCK_12H_EN
    logic        pm;
`endif
    logic        preset;
    logic [23:0] preset_val;
    int          checks, errors;

    clock_time_controller dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_tick  (tick),
        .i_mode  (mode),
        .i_inc   (inc),
        .i_digits(digits),
        .o_ena   (ena),
        .o_wr    (wr),
        .o_wdata (wdata),
        .o_mode  (omode)
`ifdef CLOCK_12H_EN
        ,
        .o_pm    (pm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decade counters: ena&wr loads, ena alone counts 9->0.
    always @(posedge clk) begin
        if (preset) begin
            digits <= preset_val;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (ena[k]) begin
                    if (wr[k])
                        digits[k*4 +: 4] <= wdata[k*4 +: 4];
                    else
                        digits[k*4 +: 4] <= (digits[k*4 +: 4] == 4'd9) ? 4'd0 : digits[k*4 +: 4] + 4'd1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic t, input logic m, input logic n);
        tick = t; mode = m; inc = n;
        cyc();
        tick = 1'b0; mode = 1'b0; inc = 1'b0;
    endtask

    task automatic load(input logic [23:0] v);
        preset_val = v;
        preset = 1'b1;
        cyc();
        preset = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [5:0] e_ena, input logic [5:0] e_wr,
                       input logic [23:0] e_wdata, input logic [1:0] e_mode);
        checks++;
        assert (ena === e_ena) else begin
            errors++; $error("FAIL %s ena got %h exp %h", tag, ena, e_ena);
        end
        checks++;
        assert (wr === e_wr) else begin
            errors++; $error("FAIL %s wr got %h exp %h", tag, wr, e_wr);
        end
        checks++;
        assert (wdata === e_wdata) else begin
            errors++; $error("FAIL %s wdata got %h exp %h", tag, wdata, e_wdata);
        end
        checks++;
        assert (omode === e_mode) else begin
            errors++; $error("FAIL %s mode got %0d exp %0d", tag, omode, e_mode);
        end
    endtask

    task automatic chk_dig(input string tag, input logic [23:0] e);
        checks++;
        assert (digits === e) else begin
            errors++; $error("FAIL %s digits got %h exp %h", tag, digits, e);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; tick = 1'b0; mode = 1'b0; inc = 1'b0;
        preset = 1'b0; preset_val = '0;
        cyc(); cyc();
        chk("reset", 6'h00, 6'h00, 24'h0, 2'd3);

        reset = 1'b0;
        cyc();
        chk("clear", 6'h3F, 6'h3F, 24'h0, 2'd3);
        cyc();
        chk("run_entry", 6'h00, 6'h00, 24'h0, 2'd0);
        chk_dig("cleared", 24'h000000);

        load(24'h000009); pulse(1, 0, 0);
        chk("sec9", 6'h03, 6'h00, 24'h0, 2'd0);
        cyc(); chk_dig("sec9_cnt", 24'h000010);

        load(24'h000059); pulse(1, 0, 0);
        chk("sec59", 6'h07, 6'h02, 24'h0, 2'd0);
        cyc(); chk_dig("sec59_cnt", 24'h000100);

        load(24'h000959); pulse(1, 0, 0);
        chk("min9", 6'h0F, 6'h02, 24'h0, 2'd0);
        cyc(); chk_dig("min9_cnt", 24'h001000);

        load(24'h095959); pulse(1, 0, 0);
        chk("hr9", 6'h3F, 6'h0A, 24'h0, 2'd0);
        cyc(); chk_dig("hr9_cnt", 24'h100000);

        load(24'h235959); pulse(1, 0, 0);
        chk("midnight", 6'h3F, 6'h3A, 24'h0, 2'd0);
        cyc(); chk_dig("midnight_cnt", 24'h000000);

        load(24'h000079); pulse(1, 0, 0);
        chk("sec_t_oor", 6'h07, 6'h02, 24'h0, 2'd0);
        cyc(); chk_dig("sec_t_oor_cnt", 24'h000100);

        pulse(0, 0, 1);
        chk("run_inc", 6'h00, 6'h00, 24'h0, 2'd0);

        load(24'h223015); pulse(0, 1, 0);
        chk("to_sethr", 6'h00, 6'h00, 24'h0, 2'd1);
        pulse(0, 0, 1);
        chk("hr23", 6'h30, 6'h30, 24'h230000, 2'd1);
        pulse(0, 0, 1);
        chk("busy", 6'h00, 6'h00, 24'h0, 2'd1);
        pulse(0, 0, 1);
        chk("hr00", 6'h30, 6'h30, 24'h000000, 2'd1);
        pulse(1, 0, 0);
        chk("tick_ign", 6'h00, 6'h00, 24'h0, 2'd1);
        pulse(0, 0, 1);
        chk("hr01", 6'h30, 6'h30, 24'h010000, 2'd1);
        cyc(); chk_dig("hr01_cnt", 24'h013015);

        pulse(0, 1, 1);
        chk("mode_inc", 6'h00, 6'h00, 24'h0, 2'd2);

        load(24'h015942); pulse(0, 0, 1);
        chk("min00", 6'h0C, 6'h0C, 24'h000000, 2'd2);
        cyc(); chk_dig("min00_cnt", 24'h010042);

        pulse(0, 1, 0);
        chk("to_run", 6'h03, 6'h03, 24'h0, 2'd0);
        cyc(); chk_dig("to_run_cnt", 24'h010000);

        load(24'h000005); pulse(1, 1, 0);
        chk("tick_mode", 6'h01, 6'h00, 24'h0, 2'd1);
        cyc(); chk_dig("tick_mode_cnt", 24'h000006);

        reset = 1'b1; cyc();
        chk("rereset", 6'h00, 6'h00, 24'h0, 2'd3);
        reset = 1'b0; cyc();
        chk("reclear", 6'h3F, 6'h3F, 24'h0, 2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
